mul_share_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined 16x16 signed multiplier (16s x 16s -> 32s, clock-enabled, fixed latency) among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per enabled cycle.
- Tracks each in-flight product with a requester tag and returns results in issue order on a single response channel.
- Stalls the multiplier through its clock enable when the response consumer applies backpressure.

---
 rtl/mul_share_sched_if.sv | 26 ++
 rtl/mul_share_sched.sv | 49 ++++
 tb/tb_mul_share_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mul_share_sched_if.sv
// mul_share_sched_if: requester, response and multiplier signals of the shared-multiplier scheduler
interface mul_share_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [31:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  logic mul_ce;
  logic [15:0] mul_din0;
  logic [15:0] mul_din1;
  logic [31:0] mul_dout;
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_dout,
    input req_ready, rsp_valid, rsp_data, rsp_id, mul_ce, mul_din0, mul_din1
  );
  modport slave (
    input req_valid, req_a, req_b, rsp_ready, mul_dout,
    output req_ready, rsp_valid, rsp_data, rsp_id, mul_ce, mul_din0, mul_din1
  );
endinterface

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin sharing of one pipelined signed multiplier among NREQ requesters
module mul_share_sched #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int MUL_LAT = 3
) (
  input logic clk,
  input logic reset,
  mul_share_sched_if.slave b,
  output logic busy
);
  logic [IDW-1:0] ptr, g, idx;
  logic hit, xfer;
  logic [MUL_LAT-1:0] vld;
  logic [MUL_LAT-1:0][IDW-1:0] ids;
  // search from ptr with wrap; descending walk so the nearest requester is assigned last and wins
  always_comb begin
    g = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (b.req_valid[idx]) begin
        hit = 1'b1;
        g = idx;
      end
    end
  end
  assign b.mul_ce = !(b.rsp_valid && !b.rsp_ready);
  assign xfer = hit && b.mul_ce;
  assign b.req_ready = xfer ? NREQ'(1) << g : '0;
  assign b.mul_din0 = xfer ? b.req_a[{g, 4'd0} +: 16] : '0;
  assign b.mul_din1 = xfer ? b.req_b[{g, 4'd0} +: 16] : '0;
  assign b.rsp_valid = vld[MUL_LAT-1];
  assign b.rsp_id = ids[MUL_LAT-1];
  assign b.rsp_data = b.mul_dout;
  assign busy = |vld;
  // tag pipeline tracks the multiplier and freezes with it; pointer moves past each granted requester
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      vld <= '0;
      ids <= '0;
      ptr <= '0;
    end else if (b.mul_ce) begin
      vld <= MUL_LAT'({vld, xfer});
      ids <= (MUL_LAT * IDW)'({ids, g});
      if (xfer) ptr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
    end
endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched: randomized and directed scoreboard bench for the shared-multiplier scheduler
module tb_mul_share_sched;
  localparam int N = 4;
  localparam int W = 2;
  localparam int L = 3;
  typedef struct {int id; int prod; int age;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic [N-1:0] rv;
  logic rr;
  shortint ra [N];
  shortint rb [N];
  logic [31:0] mp [L];
  ent_t q [$];
  int checks = 0;
  int fails = 0;
  int mptr = 0;
  int m_g;
  logic m_ev, m_ece;
  always #5 clk = ~clk;
  mul_share_sched_if #(.NREQ(N), .IDW(W)) bus();
  mul_share_sched #(.NREQ(N), .IDW(W), .MUL_LAT(L)) dut (.clk(clk), .reset(reset), .b(bus), .busy(busy));
  assign bus.req_valid = rv;
  assign bus.rsp_ready = rr;
  for (genvar i = 0; i < N; i++) begin : g_pk
    assign bus.req_a[16*i +: 16] = ra[i];
    assign bus.req_b[16*i +: 16] = rb[i];
  end
  // external multiplier: L-stage product pipeline gated by mul_ce
  always_ff @(posedge clk)
    if (bus.mul_ce) begin
      mp[0] <= $signed(bus.mul_din0) * $signed(bus.mul_din1);
      for (int k = 1; k < L; k++) mp[k] <= mp[k-1];
    end
  assign bus.mul_dout = mp[L-1];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: in-flight ops with their count of enabled edges; head is presented once it has seen L
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      mptr = 0;
    end else begin
      m_ev = q.size() > 0 && q[0].age == L;
      m_ece = !(m_ev && !rr);
      chk("rsp_valid", int'(bus.rsp_valid), int'(m_ev));
      chk("busy", int'(busy), int'(q.size() > 0));
      chk("mul_ce", int'(bus.mul_ce), int'(m_ece));
      if (m_ev) begin
        chk("rsp_data", int'(bus.rsp_data), q[0].prod);
        chk("rsp_id", int'(bus.rsp_id), q[0].id);
      end
      m_g = -1;
      if (m_ece)
        for (int k = N - 1; k >= 0; k--)
          if (rv[(mptr + k) % N]) m_g = (mptr + k) % N;
      chk("req_ready", int'(bus.req_ready), m_g < 0 ? 0 : (1 << m_g));
      chk("mul_din0", int'($signed(bus.mul_din0)), m_g < 0 ? 0 : int'(ra[m_g]));
      chk("mul_din1", int'($signed(bus.mul_din1)), m_g < 0 ? 0 : int'(rb[m_g]));
      if (m_ev && rr) void'(q.pop_front());
      if (m_ece) begin
        foreach (q[i]) q[i].age++;
        if (m_g >= 0) begin
          q.push_back('{m_g, int'(ra[m_g]) * int'(rb[m_g]), 1});
          mptr = (m_g + 1) % N;
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    rv = '0;
    repeat (n) step();
  endtask
  initial begin
    int t;
    rv = '0;
    rr = 1'b1;
    for (int k = 0; k < N; k++) begin
      ra[k] = 0;
      rb[k] = 0;
    end
    #2 reset = 1'b0;
    repeat (2) step();
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mul_ce", int'(bus.mul_ce), 1);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_din0", int'(bus.mul_din0), 0);
    chk("rst_din1", int'(bus.mul_din1), 0);
    reset = 1'b1;
    step();
    ra[0] = 3;
    rb[0] = -5;
    rv = 4'b0001;
    step();
    idle(6);
    for (int k = 0; k < N; k++) begin
      ra[k] = shortint'(k + 1);
      rb[k] = 100;
    end
    rv = 4'hF;
    repeat (8) step();
    idle(6);
    rv = 4'b0111;
    repeat (3) step();
    rv = '0;
    rr = 1'b0;
    repeat (5) step();
    rr = 1'b1;
    idle(6);
    ra[0] = -32768;
    rb[0] = -32768;
    ra[1] = 32767;
    rb[1] = -32768;
    rv = 4'b0011;
    repeat (2) step();
    idle(6);
    rr = 1'b0;
    for (int n = 0; n < 5; n++) begin
      ra[3] = shortint'(n * 7 - 11);
      rb[3] = shortint'(n + 2);
      rv = 4'b1000;
      step();
      rv = '0;
      step();
    end
    rr = 1'b1;
    idle(12);
    for (int k = 0; k < N; k++) begin
      ra[k] = shortint'($urandom);
      rb[k] = shortint'($urandom);
    end
    rv = 4'b0110;
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    chk("async_rsp_valid", int'(bus.rsp_valid), 0);
    chk("async_busy", int'(busy), 0);
    rv = 4'hF;
    step();
    step();
    reset = 1'b1;
    repeat (6) step();
    idle(6);
    repeat (500) begin
      rv = N'($urandom);
      for (int k = 0; k < N; k++) begin
        ra[k] = shortint'($urandom);
        rb[k] = shortint'($urandom);
      end
      rr = $urandom_range(0, 3) != 0;
      step();
    end
    rv = '0;
    rr = 1'b1;
    t = 0;
    while ((q.size() > 0 || busy) && t < 50) begin
      step();
      t++;
    end
    chk("drain_queue", q.size(), 0);
    chk("drain_busy", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
